// File: rtl/fft_result_writer_if.sv
// Bundles the job-control, upstream FIFO and write-channel signals of fft_result_writer.
// The slave modport is the writer's view; master is the view of whatever drives it.
interface fft_result_writer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [31:0]           ctx_length;
  logic [511:0]          fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_re;
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [511:0]          wr_req_data;
  logic                  wr_rsp_valid;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, base_addr, ctx_length, fifo_dout, fifo_empty, wr_req_ready, wr_rsp_valid,
    output fifo_re, wr_req_valid, wr_req_addr, wr_req_data, busy, done
  );

  modport master (
    output start, base_addr, ctx_length, fifo_dout, fifo_empty, wr_req_ready, wr_rsp_valid,
    input  fifo_re, wr_req_valid, wr_req_addr, wr_req_data, busy, done
  );
endinterface

// File: rtl/fft_result_writer.sv
// Streams ctx_length FFT result lines from an upstream FIFO to a write channel at
// consecutive line addresses, then waits for all write completions before pulsing done.
module fft_result_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               reset,
  fft_result_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_RSP, FIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic                  inflight_q, inflight_d;

  logic [511:0]          buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;

  logic                  push, pop, fifo_re_w, rd_room;
  logic [1:0]            occ_after_pop;

  assign push          = inflight_q;
  assign pop           = bus.wr_req_valid && bus.wr_req_ready;
  // Counting this cycle's pop as free space is what lets reads keep pace at one line per cycle.
  assign occ_after_pop = occ_q - {1'b0, pop};
  assign rd_room       = ({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2;

  assign fifo_re_w = (state_q == RUN) && !bus.fifo_empty && (rd_cnt_q < len_q) && rd_room;

  assign bus.fifo_re      = fifo_re_w;
  assign bus.wr_req_valid = (occ_q != 2'd0);
  assign bus.wr_req_data  = buf_q[rd_ptr_q];
  assign bus.wr_req_addr  = base_q + ADDR_WIDTH'(acc_cnt_q);
  assign bus.busy         = (state_q == RUN) || (state_q == WAIT_RSP);
  assign bus.done         = (state_q == FIN);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q + CNT_WIDTH'(fifo_re_w);
    acc_cnt_d  = acc_cnt_q + CNT_WIDTH'(pop);
    rsp_cnt_d  = rsp_cnt_q;
    inflight_d = fifo_re_w;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d    = bus.base_addr;
          len_d     = CNT_WIDTH'(bus.ctx_length);
          rd_cnt_d  = '0;
          acc_cnt_d = '0;
          rsp_cnt_d = '0;
          state_d   = (bus.ctx_length == 32'd0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (bus.wr_rsp_valid) rsp_cnt_d = rsp_cnt_q + 1'b1;
        if (acc_cnt_d == len_q) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (bus.wr_rsp_valid) rsp_cnt_d = rsp_cnt_q + 1'b1;
        if (rsp_cnt_d == len_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // NOTE: the two buffer entries are reset deliberately, since wr_req_data must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) buf_q[wr_ptr_q] <= bus.fifo_dout;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      occ_q    <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fft_result_writer.sv
// Scoreboard bench for fft_result_writer: a FIFO and response model drive the DUT,
// a negedge monitor pops expected requests and compares them as they are accepted.
module tb_fft_result_writer;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_result_writer_if #(.ADDR_WIDTH(AW)) bus ();

  fft_result_writer #(.ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [511:0] fifo_q     [$];
  logic [31:0]  exp_addr_q [$];
  logic [511:0] exp_data_q [$];

  int cyc = 0;
  int acc_total, rsp_sent, reads, max_ahead, done_cnt, done_cyc, last_rsp_cyc, start_cyc;
  bit rsp_hold, ready_rand, ready_val, saw_re, saw_valid, stall_pending, pend_take;
  logic [511:0] pend_line, held_data;
  logic [31:0]  held_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    compared++;
    mismatched++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [511:0] line(input int t, input int i);
    return {16{32'hD000_0000 | 32'(t << 8) | 32'(i)}};
  endfunction

  // Upstream FIFO, ready and response drivers: all change #1 after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend_take) bus.fifo_dout = pend_line;
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.wr_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    if (!rsp_hold && acc_total > rsp_sent) begin
      bus.wr_rsp_valid = 1'b1;
      rsp_sent++;
      last_rsp_cyc = cyc;
    end else begin
      bus.wr_rsp_valid = 1'b0;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every accepted request.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      pend_take     = 1'b0;
      stall_pending = 1'b0;
    end else begin
      pend_take = bus.fifo_re;
      if (bus.fifo_re) begin
        reads++;
        saw_re = 1'b1;
        if (fifo_q.size() == 0) fail("fifo_underflow", "fifo_re asserted with no line available");
        else pend_line = fifo_q.pop_front();
      end
      if (bus.wr_req_valid) begin
        saw_valid = 1'b1;
        if (stall_pending) begin
          check("hold_addr", bus.wr_req_addr, held_addr);
          check("hold_data", bus.wr_req_data, held_data);
        end
        if (bus.wr_req_ready) begin
          acc_total++;
          stall_pending = 1'b0;
          if (exp_addr_q.size() == 0) begin
            fail("unexpected_req", $sformatf("request at %0h, expected none", bus.wr_req_addr));
          end else begin
            check("req_addr", bus.wr_req_addr, exp_addr_q.pop_front());
            check("req_data", bus.wr_req_data, exp_data_q.pop_front());
          end
        end else begin
          stall_pending = 1'b1;
          held_addr     = bus.wr_req_addr;
          held_data     = bus.wr_req_data;
        end
      end else begin
        stall_pending = 1'b0;
      end
      if (reads - acc_total > max_ahead) max_ahead = reads - acc_total;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    acc_total = 0; rsp_sent = 0; reads = 0; max_ahead = 0; done_cnt = 0;
    saw_re = 1'b0; saw_valid = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] addr, input logic [511:0] data);
    fifo_q.push_back(data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  // Called at posedge+1; leaves the caller at the next posedge+1.
  task automatic start_job(input logic [31:0] base, input logic [31:0] len);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.ctx_length = len;
    start_cyc      = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_cnt < target) fail(name, "timed out waiting for done");
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n = 0;
    while (acc_total < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (acc_total < target) fail(name, "timed out waiting for accepted requests");
  endtask

  task automatic settle_and_close(input string tag, input int n_req);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_done_once"}, 512'(done_cnt), 512'(1));
    check({tag, "_busy_low"}, 512'(bus.busy), 512'(0));
    check({tag, "_accepted"}, 512'(acc_total), 512'(n_req));
    check({tag, "_sb_empty"}, 512'(exp_addr_q.size()), 512'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a1 [4] = '{32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103};
    logic [31:0] a2 [8] = '{32'h0000_2000, 32'h0000_2001, 32'h0000_2002, 32'h0000_2003,
                            32'h0000_2004, 32'h0000_2005, 32'h0000_2006, 32'h0000_2007};
    logic [31:0] a4 [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] a6 [3] = '{32'h0000_7000, 32'h0000_7001, 32'h0000_7002};
    int done_before;

    bus.start = 1'b0; bus.base_addr = '0; bus.ctx_length = '0; bus.fifo_dout = '0;
    bus.fifo_empty = 1'b1; bus.wr_req_ready = 1'b0; bus.wr_rsp_valid = 1'b0;
    rsp_hold = 1'b0; ready_rand = 1'b0; ready_val = 1'b1;
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_re", 512'(bus.fifo_re), 512'(0));
    check("rst_valid", 512'(bus.wr_req_valid), 512'(0));
    check("rst_busy", 512'(bus.busy), 512'(0));
    check("rst_done", 512'(bus.done), 512'(0));
    check("rst_addr", 512'(bus.wr_req_addr), 512'(0));
    check("rst_data", bus.wr_req_data, 512'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic job, ready held high, one response per cycle.
    clear_stats();
    for (int i = 0; i < 4; i++) push_line(a1[i], line(1, i));
    start_job(32'h0000_0100, 32'd4);
    wait_done(1, 100, "t1_done");
    settle_and_close("t1", 4);

    // Random backpressure.
    clear_stats();
    ready_rand = 1'b1;
    for (int i = 0; i < 8; i++) push_line(a2[i], line(2, i));
    start_job(32'h0000_2000, 32'd8);
    wait_done(1, 400, "t2_done");
    check("t2_read_ahead_le2", 512'(max_ahead <= 2), 512'(1));
    ready_rand = 1'b0;
    settle_and_close("t2", 8);

    // Zero-length job.
    clear_stats();
    start_job(32'h0000_3000, 32'd0);
    wait_done(1, 20, "t3_done");
    check("t3_done_latency", 512'(done_cyc), 512'(start_cyc + 1));
    check("t3_no_fifo_re", 512'(saw_re), 512'(0));
    check("t3_no_valid", 512'(saw_valid), 512'(0));
    settle_and_close("t3", 0);

    // Address wrap.
    clear_stats();
    for (int i = 0; i < 3; i++) push_line(a4[i], line(4, i));
    start_job(32'hFFFF_FFFE, 32'd3);
    wait_done(1, 100, "t4_done");
    settle_and_close("t4", 3);

    // Reset mid-job, then a fresh job right after release.
    clear_stats();
    rsp_hold = 1'b1;
    for (int i = 0; i < 6; i++) push_line(32'h0000_5000 + 32'(i), line(5, i));
    start_job(32'h0000_5000, 32'd6);
    wait_acc(2, 100, "t5_two_accepted");
    done_before = done_cnt;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_rst_fifo_re", 512'(bus.fifo_re), 512'(0));
    check("t5_rst_valid", 512'(bus.wr_req_valid), 512'(0));
    check("t5_rst_busy", 512'(bus.busy), 512'(0));
    check("t5_rst_done", 512'(bus.done), 512'(0));
    check("t5_rst_addr", 512'(bus.wr_req_addr), 512'(0));
    check("t5_rst_data", bus.wr_req_data, 512'(0));
    repeat (2) @(posedge clk);
    check("t5_no_done", 512'(done_cnt), 512'(done_before));
    fifo_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    clear_stats();
    rsp_hold = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    push_line(32'h0000_6000, line(6, 0));
    start_job(32'h0000_6000, 32'd1);
    wait_done(1, 100, "t5_restart_done");
    settle_and_close("t5", 1);

    // Responses withheld until all requests are accepted.
    clear_stats();
    rsp_hold = 1'b1;
    for (int i = 0; i < 3; i++) push_line(a6[i], line(7, i));
    start_job(32'h0000_7000, 32'd3);
    wait_acc(3, 100, "t6_all_accepted");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      check("t6_busy_held", 512'(bus.busy), 512'(1));
      check("t6_no_done", 512'(bus.done), 512'(0));
    end
    rsp_hold = 1'b0;
    wait_done(1, 50, "t6_done");
    check("t6_done_after_last_rsp", 512'(done_cyc), 512'(last_rsp_cyc + 1));
    check("t6_rsp_count", 512'(rsp_sent), 512'(3));
    settle_and_close("t6", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_result_writer.md
FFT_RESULT_WRITER -- requirements
Module: fft_result_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the line-address width of write requests.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the width of the line and response counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first line address of the job, captured on accepted start.
REQ-007 SHALL have port ctx_length  input  32  number of 512-bit lines in the job, captured on accepted start.
REQ-008 SHALL have port fifo_dout  input  512  read data from the upstream FFT/IFFT output FIFO.
REQ-009 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-010 SHALL have port fifo_re  output  1  upstream FIFO read enable; read data is valid on fifo_dout exactly one cycle after fifo_re.
REQ-011 SHALL have port wr_req_valid  output  1  write request present.
REQ-012 SHALL have port wr_req_ready  input  1  downstream accepts the request this cycle.
REQ-013 SHALL have port wr_req_addr  output  ADDR_WIDTH  line address of the request.
REQ-014 SHALL have port wr_req_data  output  512  line data of the request.
REQ-015 SHALL have port wr_rsp_valid  input  1  one write completion per asserted cycle.
REQ-016 SHALL have ports busy  output  1  (job active) and done  output  1  (one-cycle completion pulse).

Function
REQ-017 SHALL implement states IDLE, RUN, WAIT_RSP, FIN; IDLE->RUN on start; RUN->WAIT_RSP when ctx_length requests have been accepted; WAIT_RSP->FIN when ctx_length responses have been counted; FIN->IDLE unconditionally after one cycle.
REQ-018 SHALL accept start with ctx_length=0 by going IDLE->FIN directly, skipping RUN and WAIT_RSP.
REQ-019 SHALL ignore start in all states other than IDLE.
REQ-020 SHALL hold a 2-entry holding buffer between fifo_dout and the write channel.
REQ-021 SHALL assert fifo_re only in RUN, only when fifo_empty=0, and only when (lines read) < ctx_length.
REQ-022 SHALL additionally assert fifo_re only when (buffer occupancy + reads in flight) < 2, so the buffer never overflows.
REQ-023 SHALL write fifo_dout into the buffer in the cycle after each fifo_re.
REQ-024 SHALL drive wr_req_valid=1 whenever the buffer is non-empty, presenting the oldest entry on wr_req_data.
REQ-025 SHALL drive wr_req_addr = base_addr + (requests accepted so far), computed modulo 2^ADDR_WIDTH.
REQ-026 SHALL keep wr_req_addr and wr_req_data stable while wr_req_valid=1 and wr_req_ready=0.
REQ-027 SHALL treat a request as accepted when wr_req_valid=1 and wr_req_ready=1 in the same cycle, and SHALL then pop the buffer.
REQ-028 SHALL allow a buffer push and pop in the same cycle, leaving occupancy unchanged.
REQ-029 SHALL count wr_rsp_valid in RUN and in WAIT_RSP, including responses arriving before all requests are issued.
REQ-030 SHALL drop wr_rsp_valid pulses received in IDLE or FIN.
REQ-031 SHALL sustain one request per cycle when the FIFO stays non-empty and wr_req_ready is held at 1.
REQ-032 SHALL drive busy=1 in RUN and WAIT_RSP, and SHALL pulse done=1 for exactly the one cycle spent in FIN.

Reset
REQ-033 SHALL, on reset assertion and independent of clk, force state to IDLE and clear the buffer, all counters and the in-flight flag.
REQ-034 SHALL drive fifo_re=0, wr_req_valid=0, busy=0 and done=0 while reset is asserted.
REQ-035 SHALL clear wr_req_addr and wr_req_data to 0 on reset.
REQ-036 SHALL abandon any job in progress when reset is asserted mid-job, with no done pulse.
REQ-037 SHALL accept a new start in the first cycle after reset deasserts.

Verification
REQ-038 Bench SHALL cover: base_addr=0x100, ctx_length=4, FIFO preloaded with 4 lines, ready=1, one response per cycle -> requests at addresses 0x100..0x103 in order with matching data, then done pulses once and busy falls.
REQ-039 Bench SHALL cover: ctx_length=8, wr_req_ready toggled randomly -> exactly 8 accepted requests, data/addr held stable while stalled, at most 2 lines read ahead of acceptance.
REQ-040 Bench SHALL cover: ctx_length=0 -> done 1 cycle after start, no fifo_re and no wr_req_valid.
REQ-041 Bench SHALL cover: base_addr=0xFFFFFFFE, ctx_length=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-042 Bench SHALL cover: reset asserted after 2 of 6 requests -> outputs 0 immediately, no done; a new start with ctx_length=1 then completes normally.
REQ-043 Bench SHALL cover: all responses withheld until requests finish -> state held in WAIT_RSP with busy=1; done pulses in the cycle after the last response is counted.
